// File: rtl/vx_tcu_drl_norm_round_pkg.sv
// Shared FP32 constants and flag layout for the DRL TCU dot-product back end.
package vx_tcu_drl_norm_round_pkg;

    localparam int F32_BIAS     = 127;
    localparam int F32_SIG_BITS = 23;
    localparam int F32_EXP_MAX  = 255;

    localparam logic [31:0] F32_CANON_NAN = 32'h7FC00000;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fedp_fflags_t;

endpackage

// File: rtl/vx_lzc.sv
// Leading-zero counter; REVERSE=1 counts from the MSB, REVERSE=0 from the LSB.
module vx_lzc #(
    parameter int N       = 2,
    parameter int REVERSE = 0,
    localparam int LOGN   = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    data_in,
    output logic [LOGN-1:0] data_out
);

    // The last matching bit in scan order wins, so an all-zero input reads as 0.
    always_comb begin
        data_out = '0;
        if (REVERSE != 0) begin
            for (int i = 0; i < N; i++) begin
                if (data_in[i]) data_out = LOGN'(N - 1 - i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (data_in[i]) data_out = LOGN'(i);
            end
        end
    end

endmodule

// File: rtl/vx_pipe_register.sv
// Enable-gated pipeline register with synchronous clear of the whole payload.
module vx_pipe_register #(
    parameter int DATAW = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out
);

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
        end else if (enable) begin
            data_out <= data_in;
        end
    end

endmodule

// File: rtl/vx_tcu_drl_norm_round.sv
// Normalize, re-bias and RNE-round the aligned accumulator into FP32 with fflags.
// Three elastic stages: magnitude/LZC, shift/exponent, round/pack.
module vx_tcu_drl_norm_round
    import vx_tcu_drl_norm_round_pkg::*;
#(
    parameter int ACC_W = 30,
    parameter int EXP_W = 10,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [ACC_W-1:0] acc_in,
    input  logic [EXP_W-1:0] exp_lsb,
    input  logic             is_nan,
    input  logic             is_inf,
    input  logic             inf_sign,
    input  logic [TAG_W-1:0] tag_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [31:0]      result,
    output logic [4:0]       fflags,
    output logic [TAG_W-1:0] tag_out
);

    localparam int LZW = $clog2(ACC_W);
    localparam int FW  = ACC_W - 1;
    localparam int GS  = FW - F32_SIG_BITS;
    localparam int EW  = EXP_W + 1;
    localparam int SW  = F32_SIG_BITS;

    localparam int S1W = 1 + 1 + FW + LZW + 1 + EXP_W + 3 + TAG_W;
    localparam int S2W = 1 + 1 + EW + SW + 2 + 1 + 3 + TAG_W;
    localparam int S3W = 1 + 32 + 5 + TAG_W;

    localparam logic signed [EW-1:0] E_MAX = EW'(F32_EXP_MAX);

    logic s1_valid, s2_valid, s3_valid;
    logic s1_en, s2_en, s3_en;

    // A stage loads whenever it is empty or its contents move on this edge.
    assign s3_en    = !s3_valid || ready_out;
    assign s2_en    = !s2_valid || s3_en;
    assign s1_en    = !s1_valid || s2_en;
    assign ready_in = s1_en;

    logic [ACC_W-1:0] s0_mag;
    logic [LZW-1:0]   s0_lz;
    logic             s0_zero;

    assign s0_mag  = acc_in[ACC_W-1] ? -acc_in : acc_in;
    assign s0_zero = (s0_mag == '0);

    vx_lzc #(
        .N       (ACC_W),
        .REVERSE (1)
    ) lzc (
        .data_in  (s0_mag),
        .data_out (s0_lz)
    );

    logic             s1_sign, s1_zero, s1_nan, s1_inf, s1_inf_sign;
    logic [FW-1:0]    s1_frac;
    logic [LZW-1:0]   s1_lz;
    logic [EXP_W-1:0] s1_exp;
    logic [TAG_W-1:0] s1_tag;

    // Only the bits below the MSB are kept: the MSB shifts out during normalization.
    vx_pipe_register #(.DATAW(S1W)) s1_reg (
        .clk      (clk),
        .reset    (reset),
        .enable   (s1_en),
        .data_in  ({valid_in, acc_in[ACC_W-1], s0_mag[FW-1:0], s0_lz, s0_zero,
                    exp_lsb, is_nan, is_inf, inf_sign, tag_in}),
        .data_out ({s1_valid, s1_sign, s1_frac, s1_lz, s1_zero,
                    s1_exp, s1_nan, s1_inf, s1_inf_sign, s1_tag})
    );

    logic [FW-1:0] s1_norm;
    logic [EW-1:0] s1_e;

    assign s1_norm = s1_frac << s1_lz;
    assign s1_e    = {s1_exp[EXP_W-1], s1_exp} + EW'(ACC_W - 1) - EW'(s1_lz);

    logic             s2_sign, s2_zero, s2_nan, s2_inf, s2_inf_sign;
    logic             s2_guard, s2_sticky;
    logic [EW-1:0]    s2_e;
    logic [SW-1:0]    s2_mant;
    logic [TAG_W-1:0] s2_tag;

    vx_pipe_register #(.DATAW(S2W)) s2_reg (
        .clk      (clk),
        .reset    (reset),
        .enable   (s2_en),
        .data_in  ({s1_valid, s1_sign, s1_e, s1_norm[FW-1 -: SW],
                    s1_norm[GS-1], |s1_norm[GS-2:0],
                    s1_zero, s1_nan, s1_inf, s1_inf_sign, s1_tag}),
        .data_out ({s2_valid, s2_sign, s2_e, s2_mant,
                    s2_guard, s2_sticky,
                    s2_zero, s2_nan, s2_inf, s2_inf_sign, s2_tag})
    );

    logic          s2_round_up;
    logic [SW:0]   s2_mant_rnd;
    logic [EW-1:0] s2_e_rnd;
    logic [31:0]   s2_result;
    fedp_fflags_t  s2_flags;

    assign s2_round_up = s2_guard && (s2_sticky || s2_mant[0]);
    assign s2_mant_rnd = {1'b0, s2_mant} + (SW + 1)'(s2_round_up);
    assign s2_e_rnd    = s2_e + EW'(s2_mant_rnd[SW]);

    // Underflow is judged on the pre-rounding exponent; subnormals are never produced.
    always_comb begin
        s2_result = '0;
        s2_flags  = '0;
        if (s2_nan) begin
            s2_result   = F32_CANON_NAN;
            s2_flags.nv = 1'b1;
        end else if (s2_inf) begin
            s2_result = {s2_inf_sign, 8'hFF, 23'd0};
        end else if (s2_zero) begin
            s2_result = '0;
        end else if (s2_e[EW-1] || (s2_e == '0)) begin
            s2_result   = {s2_sign, 31'd0};
            s2_flags.uf = 1'b1;
            s2_flags.nx = 1'b1;
        end else if ($signed(s2_e_rnd) >= E_MAX) begin
            s2_result   = {s2_sign, 8'hFF, 23'd0};
            s2_flags.of = 1'b1;
            s2_flags.nx = 1'b1;
        end else begin
            s2_result   = {s2_sign, s2_e_rnd[7:0], s2_mant_rnd[SW-1:0]};
            s2_flags.nx = s2_guard | s2_sticky;
        end
    end

    vx_pipe_register #(.DATAW(S3W)) s3_reg (
        .clk      (clk),
        .reset    (reset),
        .enable   (s3_en),
        .data_in  ({s2_valid, s2_result, s2_flags, s2_tag}),
        .data_out ({s3_valid, result, fflags, tag_out})
    );

    assign valid_out = s3_valid;

endmodule
